// File: rtl/lc3_pipe_ctrl.sv
// lc3_pipe_ctrl -- pipeline sequencing controller for the LC3 core.
//
// Generates the per-stage enables around decode. After reset the pipe fills
// one stage per cycle. In steady state a memory instruction in execute
// freezes the whole pipe until the data access completes, and a BR/JMP
// leaving decode holds fetch/PC update for BR_BUBBLES cycles. A one-cycle
// br_taken pulse is raised in the last of those cycles when the PC should
// be redirected.
//
// Optional build macro: LC3_CTRL_STALL_CNT_EN adds a saturating
// stall_count output that counts fetch-stalled cycles outside FILL.
//
// Ports:
//   clock            pipeline clock, rising edge
//   reset            synchronous active-high reset
//   Instr_Reg[15:0]  instruction at decode output (control-op detection)
//   IR_Exec[15:0]    instruction in execute (memory-op detection)
//   npc_out[15:0]    decode NPC, trace only
//   en_de            decode enable as seen at decode output
//   psr[2:0]         NZP flags
//   complete_data    data memory access finished this cycle
//   enable_updatePC / enable_fetch / enable_decode / enable_execute /
//   enable_writeback stage enables (registered)
//   br_taken         one-cycle PC redirect pulse (registered)
//   mem_state[1:0]   0=read, 1=indirect read, 2=write, 3=idle (registered)
//   stall_count[15:0] only with LC3_CTRL_STALL_CNT_EN
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_FILL    | post-reset fill, stages switched on one per cycle
// ST_RUN     | all stages enabled, watching for memory/control ops
// ST_MEM_RD  | pipe frozen, data read in progress
// ST_MEM_WR  | pipe frozen, data write in progress
// ST_MEM_IND | pipe frozen, pointer read of LDI/STI in progress
// ST_BR_WAIT | fetch/PC held while a BR/JMP resolves

module lc3_pipe_ctrl #(
  parameter int BR_BUBBLES  = 3,
  parameter int FILL_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] Instr_Reg,
  input  logic [15:0] IR_Exec,
  input  logic [15:0] npc_out,
  input  logic        en_de,
  input  logic [2:0]  psr,
  input  logic        complete_data,
  output logic        enable_updatePC,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic [1:0]  mem_state
`ifdef LC3_CTRL_STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_JMP = 4'b1100;

  localparam logic [1:0] MS_RD   = 2'd0;
  localparam logic [1:0] MS_IND  = 2'd1;
  localparam logic [1:0] MS_WR   = 2'd2;
  localparam logic [1:0] MS_IDLE = 2'd3;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_RUN,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_MEM_IND,
    ST_BR_WAIT
  } state_t;

  state_t      state_q;
  logic [7:0]  fill_q;
  logic [2:0]  bub_q;
  logic        store_q;
  logic        jmp_q;
  logic [2:0]  nzp_q;
  logic        en_pc_q, en_fetch_q, en_dec_q, en_exe_q, en_wb_q;
  logic        br_taken_q;
  logic [1:0]  mem_state_q;

  logic [3:0]  op_de, op_ex;
  logic        ex_is_mem, de_is_ctrl;

  assign op_de = Instr_Reg[15:12];
  assign op_ex = IR_Exec[15:12];

  // Memory opcodes are exactly the ones with bits [13:12] != 00 among
  // {0010,0011,0110,0111,1010,1011}; listing them keeps it readable.
  always_comb begin
    ex_is_mem = 1'b0;
    case (op_ex)
      4'b0010, 4'b0110, 4'b1010,
      4'b0011, 4'b0111, 4'b1011: ex_is_mem = 1'b1;
      default:                   ex_is_mem = 1'b0;
    endcase
  end

  assign de_is_ctrl = (op_de == OP_BR) || (op_de == OP_JMP);

  // Instruction fields not needed for sequencing decisions.
  logic unused_bits;
  assign unused_bits = ^{npc_out, Instr_Reg[8:0], IR_Exec[11:0]};

  function automatic logic redirect(input logic is_jmp, input logic [2:0] nzp,
                                    input logic [2:0] flags);
    return is_jmp | (|(nzp & flags));
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FILL;
      fill_q      <= 8'd0;
      bub_q       <= 3'd0;
      store_q     <= 1'b0;
      jmp_q       <= 1'b0;
      nzp_q       <= 3'd0;
      en_pc_q     <= 1'b0;
      en_fetch_q  <= 1'b0;
      en_dec_q    <= 1'b0;
      en_exe_q    <= 1'b0;
      en_wb_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      mem_state_q <= MS_IDLE;
    end else begin
      br_taken_q <= 1'b0;
      case (state_q)
        ST_FILL: begin
          // fill_q counts edges already taken; this edge produces cycle fill_q+1.
          fill_q      <= fill_q + 8'd1;
          en_pc_q     <= 1'b1;
          en_fetch_q  <= 1'b1;
          en_dec_q    <= (fill_q >= 8'd1);
          en_exe_q    <= (fill_q >= 8'd2);
          mem_state_q <= MS_IDLE;
          if (fill_q == 8'(FILL_CYCLES)) begin
            en_wb_q <= 1'b1;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          mem_state_q <= MS_IDLE;
          if (ex_is_mem) begin
            // Memory stall takes priority; a control op waiting in decode is
            // picked up again once the pipe resumes.
            en_pc_q    <= 1'b0;
            en_fetch_q <= 1'b0;
            en_dec_q   <= 1'b0;
            en_exe_q   <= 1'b0;
            en_wb_q    <= 1'b0;
            store_q    <= IR_Exec[12];
            if (IR_Exec[15]) begin
              state_q     <= ST_MEM_IND;
              mem_state_q <= MS_IND;
            end else if (IR_Exec[12]) begin
              state_q     <= ST_MEM_WR;
              mem_state_q <= MS_WR;
            end else begin
              state_q     <= ST_MEM_RD;
              mem_state_q <= MS_RD;
            end
          end else if (en_de && de_is_ctrl) begin
            en_pc_q    <= 1'b0;
            en_fetch_q <= 1'b0;
            en_dec_q   <= 1'b1;
            en_exe_q   <= 1'b1;
            en_wb_q    <= 1'b1;
            jmp_q      <= (op_de == OP_JMP);
            nzp_q      <= Instr_Reg[11:9];
            bub_q      <= 3'(BR_BUBBLES - 1);
            // With a single bubble the entry cycle is also the final one.
            br_taken_q <= (BR_BUBBLES == 1) &&
                          redirect(op_de == OP_JMP, Instr_Reg[11:9], psr);
            state_q    <= ST_BR_WAIT;
          end else begin
            en_pc_q    <= 1'b1;
            en_fetch_q <= 1'b1;
            en_dec_q   <= 1'b1;
            en_exe_q   <= 1'b1;
            en_wb_q    <= 1'b1;
          end
        end

        ST_MEM_IND: begin
          if (complete_data) begin
            state_q     <= store_q ? ST_MEM_WR : ST_MEM_RD;
            mem_state_q <= store_q ? MS_WR : MS_RD;
          end
        end

        ST_MEM_RD, ST_MEM_WR: begin
          if (complete_data) begin
            state_q     <= ST_RUN;
            mem_state_q <= MS_IDLE;
            en_pc_q     <= 1'b1;
            en_fetch_q  <= 1'b1;
            en_dec_q    <= 1'b1;
            en_exe_q    <= 1'b1;
            // Stores have nothing to write back on the resume cycle.
            en_wb_q     <= (state_q == ST_MEM_RD);
          end
        end

        ST_BR_WAIT: begin
          if (bub_q == 3'd0) begin
            state_q    <= ST_RUN;
            en_pc_q    <= 1'b1;
            en_fetch_q <= 1'b1;
          end else begin
            bub_q      <= bub_q - 3'd1;
            br_taken_q <= (bub_q == 3'd1) && redirect(jmp_q, nzp_q, psr);
          end
        end

        default: begin
          state_q     <= ST_FILL;
          fill_q      <= 8'd0;
          en_pc_q     <= 1'b0;
          en_fetch_q  <= 1'b0;
          en_dec_q    <= 1'b0;
          en_exe_q    <= 1'b0;
          en_wb_q     <= 1'b0;
          mem_state_q <= MS_IDLE;
        end
      endcase
    end
  end

`ifdef LC3_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else if ((state_q != ST_FILL) && !en_fetch_q && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end
  assign stall_count = stall_cnt_q;
`endif

  assign enable_updatePC  = en_pc_q;
  assign enable_fetch     = en_fetch_q;
  assign enable_decode    = en_dec_q;
  assign enable_execute   = en_exe_q;
  assign enable_writeback = en_wb_q;
  assign br_taken         = br_taken_q;
  assign mem_state        = mem_state_q;

endmodule

// File: tb/tb_lc3_pipe_ctrl.sv
module tb_lc3_pipe_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Instr_Reg = 16'h0000;
  logic [15:0] IR_Exec = 16'h0000;
  logic [15:0] npc_out = 16'h3000;
  logic        en_de = 1'b0;
  logic [2:0]  psr = 3'b000;
  logic        complete_data = 1'b0;
  logic        enable_updatePC, enable_fetch, enable_decode, enable_execute;
  logic        enable_writeback, br_taken;
  logic [1:0]  mem_state;
`ifdef LC3_CTRL_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  lc3_pipe_ctrl #(.BR_BUBBLES(3), .FILL_CYCLES(3)) dut (
    .clock(clock),
    .reset(reset),
    .Instr_Reg(Instr_Reg),
    .IR_Exec(IR_Exec),
    .npc_out(npc_out),
    .en_de(en_de),
    .psr(psr),
    .complete_data(complete_data),
    .enable_updatePC(enable_updatePC),
    .enable_fetch(enable_fetch),
    .enable_decode(enable_decode),
    .enable_execute(enable_execute),
    .enable_writeback(enable_writeback),
    .br_taken(br_taken),
    .mem_state(mem_state)
`ifdef LC3_CTRL_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Expected vector layout: {updatePC, fetch, decode, execute, writeback, br_taken, mem_state[1:0]}
  typedef struct {
    int         cyc;
    logic [7:0] exp;
    string      name;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] ev(input logic pc, input logic f, input logic d,
                                     input logic x, input logic w, input logic b,
                                     input logic [1:0] ms);
    return {pc, f, d, x, w, b, ms};
  endfunction

  localparam logic [7:0] E_RST  = 8'b00000_0_11;
  localparam logic [7:0] E_RUN  = 8'b11111_0_11;
  localparam logic [7:0] E_RD   = 8'b00000_0_00;
  localparam logic [7:0] E_IND  = 8'b00000_0_01;
  localparam logic [7:0] E_WR   = 8'b00000_0_10;
  localparam logic [7:0] E_BUB  = 8'b00111_0_11;
  localparam logic [7:0] E_BUBT = 8'b00111_1_11;

  // Monitor: each cycle, compare the DUT outputs against the scoreboard entry due now.
  always @(negedge clock) begin
    logic [7:0] act;
    act = {enable_updatePC, enable_fetch, enable_decode, enable_execute,
           enable_writeback, br_taken, mem_state};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      total++;
      bad++;
      $display("FAIL %s: expected sample at cycle %0d was missed (now %0d)",
               sb[0].name, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      total++;
      if (act !== sb[0].exp) begin
        bad++;
        $display("FAIL %s: cycle %0d got %b need %b (pc,f,d,x,w,br,ms)",
                 sb[0].name, cyc, act, sb[0].exp);
      end
      void'(sb.pop_front());
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic drive(input logic rst, input logic [15:0] ir, input logic [15:0] irx,
                       input logic ende, input logic [2:0] flags, input logic cd,
                       input logic [7:0] exp, input string name);
    sb_item_t it;
    @(negedge clock);
    #1;
    reset         = rst;
    Instr_Reg     = ir;
    IR_Exec       = irx;
    en_de         = ende;
    psr           = flags;
    complete_data = cd;
    it.cyc  = cyc + 1;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
  endtask

  task automatic fill_seq(input string tag);
    drive(0, 16'h0, 16'h0, 0, 3'b000, 0, ev(1,1,0,0,0,0,2'd3), {tag, "_fill1"});
    drive(0, 16'h0, 16'h0, 0, 3'b000, 0, ev(1,1,1,0,0,0,2'd3), {tag, "_fill2"});
    drive(0, 16'h0, 16'h0, 0, 3'b000, 0, ev(1,1,1,1,0,0,2'd3), {tag, "_fill3"});
    drive(0, 16'h0, 16'h0, 0, 3'b000, 0, E_RUN, {tag, "_fill4"});
    drive(0, 16'h0, 16'h0, 0, 3'b000, 0, E_RUN, {tag, "_run"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles, then fill.
    drive(1, 16'h0, 16'h0, 0, 3'b000, 0, E_RST, "rst0");
    drive(1, 16'h0, 16'h0, 0, 3'b000, 0, E_RST, "rst1");
    fill_seq("boot");

    // complete_data outside a memory state has no effect.
    drive(0, 16'h0, 16'h0, 0, 3'b000, 1, E_RUN, "stray_cd");

    // LD: four stalled read cycles, then resume with writeback.
    drive(0, 16'h0, 16'h2A05, 0, 3'b000, 0, E_RD, "ld_s1");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_RD, "ld_s2");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_RD, "ld_s3");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_RD, "ld_s4");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 1, E_RUN, "ld_resume");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_RUN, "ld_run");

    // LDI: indirect read, then data read, then resume.
    drive(0, 16'h0, 16'hA403, 0, 3'b000, 0, E_IND, "ldi_ind1");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_IND, "ldi_ind2");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 1, E_RD, "ldi_rd1");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_RD, "ldi_rd2");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 1, E_RUN, "ldi_resume");

    // STI: indirect then write; resume without writeback.
    drive(0, 16'h0, 16'hB403, 0, 3'b000, 0, E_IND, "sti_ind");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 1, E_WR, "sti_wr");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 1, ev(1,1,1,1,0,0,2'd3), "sti_resume");

    // ST: write stall, resume cycle has writeback low.
    drive(0, 16'h0, 16'h3403, 0, 3'b000, 0, E_WR, "st_wr1");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_WR, "st_wr2");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 1, ev(1,1,1,1,0,0,2'd3), "st_resume");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_RUN, "st_run");

    // BRz with Z set: taken in the third bubble.
    drive(0, 16'h0405, 16'h0, 1, 3'b010, 0, E_BUB, "brz_b1");
    drive(0, 16'h0000, 16'h0, 0, 3'b010, 0, E_BUB, "brz_b2");
    drive(0, 16'h0000, 16'h0, 0, 3'b010, 0, E_BUBT, "brz_b3");
    drive(0, 16'h0000, 16'h0, 0, 3'b010, 0, E_RUN, "brz_run");

    // BRz with N set: not taken.
    drive(0, 16'h0405, 16'h0, 1, 3'b100, 0, E_BUB, "brzn_b1");
    drive(0, 16'h0000, 16'h0, 0, 3'b100, 0, E_BUB, "brzn_b2");
    drive(0, 16'h0000, 16'h0, 0, 3'b100, 0, E_BUB, "brzn_b3");
    drive(0, 16'h0000, 16'h0, 0, 3'b100, 0, E_RUN, "brzn_run");

    // BR with nzp=000 is never taken, even with all flags set.
    drive(0, 16'h0005, 16'h0, 1, 3'b111, 0, E_BUB, "brnv_b1");
    drive(0, 16'h0000, 16'h0, 0, 3'b111, 0, E_BUB, "brnv_b2");
    drive(0, 16'h0000, 16'h0, 0, 3'b111, 0, E_BUB, "brnv_b3");
    drive(0, 16'h0000, 16'h0, 0, 3'b111, 0, E_RUN, "brnv_run");

    // Control op in decode without en_de is ignored.
    drive(0, 16'h0405, 16'h0, 0, 3'b010, 0, E_RUN, "br_no_ende");

    // JMP in decode with LDR in execute: memory first, then the jump.
    drive(0, 16'hC1C0, 16'h6200, 1, 3'b000, 0, E_RD, "jmp_ldr_rd");
    drive(0, 16'hC1C0, 16'h0000, 1, 3'b000, 1, E_RUN, "jmp_ldr_resume");
    drive(0, 16'hC1C0, 16'h0000, 1, 3'b000, 0, E_BUB, "jmp_b1");
    drive(0, 16'h0000, 16'h0000, 0, 3'b000, 0, E_BUB, "jmp_b2");
    drive(0, 16'h0000, 16'h0000, 0, 3'b000, 0, E_BUBT, "jmp_b3");
    // Reset while still in BR_WAIT.
    drive(1, 16'h0000, 16'h0000, 0, 3'b000, 0, E_RST, "jmp_rst");
    drive(1, 16'h0000, 16'h0000, 0, 3'b000, 0, E_RST, "jmp_rst2");
    fill_seq("reboot");

    // Reset in the middle of a memory stall.
    drive(0, 16'h0, 16'h6200, 0, 3'b000, 0, E_RD, "ldr_rd");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, E_RD, "ldr_rd2");
    drive(1, 16'h0, 16'h0000, 0, 3'b000, 1, E_RST, "ldr_rst");
    drive(0, 16'h0, 16'h0000, 0, 3'b000, 0, ev(1,1,0,0,0,0,2'd3), "ldr_fill1");

    // Let the monitor consume the last entries.
    repeat (3) @(negedge clock);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d scoreboard entries left unchecked, need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lc3_pipe_ctrl.md
Name: lc3_pipe_ctrl

Overview:
Pipeline sequencing controller for the LC3 core.
- Drives the per-stage enables (fetch, decode, execute, writeback, PC update) that gate the decode stage and its neighbours.
- Stalls the pipe for memory instructions and inserts bubbles for control-flow instructions.
- Sits beside decode and consumes its instruction-register and decode-enable outputs to decide when to stall.

Parameters:
BR_BUBBLES, 3, number of cycles fetch/PC update are held after a BR/JMP enters decode (1..7)
FILL_CYCLES, 3, cycles after reset before writeback enable first asserts

Ports:
clock  input  1  pipeline clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
Instr_Reg  input  16  instruction currently at decode output
IR_Exec  input  16  instruction currently in execute
npc_out  input  16  decode NPC (for JMP detection trace only, not used in logic)
en_de  input  1  decode-stage enable as seen at decode output
psr  input  3  processor status NZP flags
complete_data  input  1  data memory access finished this cycle
enable_updatePC  output  1  PC register update enable
enable_fetch  output  1  fetch stage enable
enable_decode  output  1  decode stage enable
enable_execute  output  1  execute stage enable
enable_writeback  output  1  writeback stage enable
br_taken  output  1  one-cycle pulse, redirect PC
mem_state  output  2  0=read, 1=indirect read, 2=write, 3=idle

Behaviour:
- Reset (reset=1 at edge):
  - All enables=0, br_taken=0, mem_state=3.
  - State=FILL, fill counter=0.
- FILL:
  - Cycle 1 after reset release: enable_fetch=enable_updatePC=1.
  - Cycle 2: enable_decode=1.
  - Cycle 3: enable_execute=1.
  - Cycle FILL_CYCLES+1: enable_writeback=1, then go to RUN.
- RUN: all enables=1, mem_state=3.
- Opcode = bits [15:12]. Memory opcodes: LD=0010, LDR=0110, LDI=1010, ST=0011, STR=0111, STI=1011. Control opcodes: BR=0000, JMP=1100.
- Memory ops, decided on IR_Exec:
  - If IR_Exec holds a memory op while in RUN, the next cycle deasserts fetch/updatePC/decode/execute/writeback.
  - Next state:
    - LD/LDR → MEM_RD (mem_state=0)
    - ST/STR → MEM_WR (mem_state=2)
    - LDI/STI → MEM_IND (mem_state=1)
- MEM_IND:
  - On complete_data=1: LDI → MEM_RD, STI → MEM_WR.
- MEM_RD/MEM_WR:
  - Hold until complete_data=1.
  - Next cycle: mem_state=3, enable_writeback=1 (loads only; stores keep writeback=0 that cycle), other enables=1, return to RUN.
- Control ops, decided on Instr_Reg when en_de=1 in RUN:
  - Enter BR_WAIT: enable_fetch=enable_updatePC=0 for BR_BUBBLES cycles; decode/execute/writeback stay 1.
  - In the final BR_WAIT cycle, br_taken=1 if JMP, or if BR and (Instr_Reg[11:9] & psr)!=0. Otherwise br_taken=0.
  - BR with nzp=000 is never taken.
  - br_taken is high for exactly one cycle, then RUN.
- Simultaneous events:
  - Memory op in execute together with control op in decode: memory stall wins.
  - The control op is re-evaluated after return to RUN.
- complete_data while not in a MEM state is ignored.
- Reset mid-stall or mid-BR_WAIT aborts immediately to the reset values.
- All outputs are registered: no combinational path from inputs to outputs.

Optional Feature:
Macro LC3_CTRL_STALL_CNT_EN.
- Defined:
  - Adds output stall_count[15:0], incremented each cycle that enable_fetch=0 outside FILL.
  - Saturates at 16'hFFFF; cleared by reset.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset held 2 cycles, then released:
  - all enables 0 during reset
  - fetch=1 at cycle 1, decode=1 at cycle 2, execute=1 at cycle 3, writeback=1 at cycle 4
  - mem_state=3 throughout
- IR_Exec=16'h2A05 (LD) in RUN, complete_data after 4 cycles:
  - mem_state=0 for 4 cycles, all enables 0
  - then all 1, mem_state=3
- IR_Exec=16'hA403 (LDI): mem_state 1 until first complete_data, then 0 until second complete_data, then RUN.
- IR_Exec=16'h3403 (ST): mem_state=2; the resume cycle has writeback=0 and the other enables=1.
- Instr_Reg=16'h0405 (BRz), en_de=1, psr=3'b010:
  - fetch/updatePC low 3 cycles
  - br_taken=1 in the 3rd cycle
  - with psr=3'b100, br_taken stays 0
- Instr_Reg=16'hC1C0 (JMP) and IR_Exec=16'h6200 (LDR) in the same cycle:
  - MEM_RD is entered first
  - BR_WAIT follows after complete_data
  - br_taken=1
  - reset asserted in BR_WAIT returns all outputs to reset values next cycle
